// File: rtl/bpf_axilite_code_loader_if.sv
// AXI-Lite write-channel bundle between the code loader (master) and the
// packet filter's register slave.
interface bpf_axilite_code_loader_if #(
  parameter int AXI_ADDR_WIDTH = 12
);
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/bpf_axilite_code_loader.sv
// Streams 64-bit BPF instructions into the filter over AXI-Lite: stop, reset code
// pointer, write LO/HI per instruction, restart on TLAST. Define LOADER_TIMEOUT_EN for a B/AW/W watchdog.
module bpf_axilite_code_loader #(
  parameter int                        AXI_ADDR_WIDTH  = 12,
  parameter int                        CODE_ADDR_WIDTH = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = 'h000,
  parameter int                        TIMEOUT_CYCLES  = 1024
) (
  input  logic                         axi_aclk,
  input  logic                         axi_areset,
  input  logic [63:0]                  instr_TDATA,
  input  logic                         instr_TVALID,
  input  logic                         instr_TLAST,
  output logic                         instr_TREADY,
  bpf_axilite_code_loader_if.master    m_axi,
  output logic                         busy,
  output logic                         done,
  output logic                         err_resp,
  output logic                         err_ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_PTR, S_FETCH, S_LO, S_HI, S_RUN, S_DRAIN
  } state_t;

  localparam logic [CODE_ADDR_WIDTH:0] DEPTH = {1'b1, {CODE_ADDR_WIDTH{1'b0}}};

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                   state, state_n;
  logic                     awvalid_q, awvalid_n;
  logic                     wvalid_q, wvalid_n;
  logic                     bready_q, bready_n;
  logic                     busy_n, done_n, err_resp_n, err_ovf_n;
  logic [CODE_ADDR_WIDTH:0] count_q, count_n;
  logic                     tlast_q, tlast_n;
  logic [63:0]              instr_q;
  logic                     fetch_fire;
  logic [AXI_ADDR_WIDTH-1:0] offset;

`ifdef LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_n;
`endif

  assign instr_TREADY  = (state == S_FETCH) || (state == S_DRAIN);
  assign fetch_fire    = (state == S_FETCH) && instr_TVALID;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.awaddr  = BASE_ADDR + offset;

  // Address and data are pure functions of state/latched word, so they hold until accepted
  always_comb begin
    offset       = '0;
    m_axi.wdata  = 32'd0;
    case (state)
      S_PTR:   offset = AXI_ADDR_WIDTH'(4'h4);
      S_LO:    begin offset = AXI_ADDR_WIDTH'(4'h8); m_axi.wdata = instr_q[31:0];  end
      S_HI:    begin offset = AXI_ADDR_WIDTH'(4'hC); m_axi.wdata = instr_q[63:32]; end
      S_RUN:   m_axi.wdata = 32'd1;
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    awvalid_n  = awvalid_q;
    wvalid_n   = wvalid_q;
    bready_n   = bready_q;
    busy_n     = busy;
    done_n     = 1'b0;
    err_resp_n = err_resp;
    err_ovf_n  = err_ovf;
    count_n    = count_q;
    tlast_n    = tlast_q;
`ifdef LOADER_TIMEOUT_EN
    wd_n       = wd_q;
`endif
    case (state)
      S_IDLE: if (instr_TVALID) begin
        state_n    = S_STOP;
        awvalid_n  = 1'b1;
        wvalid_n   = 1'b1;
        busy_n     = 1'b1;
        err_resp_n = 1'b0;
        err_ovf_n  = 1'b0;
        count_n    = '0;
        tlast_n    = 1'b0;
      end
      S_FETCH: if (instr_TVALID) begin
        tlast_n = instr_TLAST;
        if (count_q == DEPTH) begin
          err_ovf_n = 1'b1;
          state_n   = instr_TLAST ? S_IDLE : S_DRAIN;
          busy_n    = !instr_TLAST;
        end else begin
          state_n   = S_LO;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
        end
      end
      S_DRAIN: if (instr_TVALID && instr_TLAST) begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        awvalid_n = awvalid_q && !m_axi.awready;
        wvalid_n  = wvalid_q && !m_axi.wready;
        if (!bready_q && !awvalid_n && !wvalid_n) bready_n = 1'b1;
`ifdef LOADER_TIMEOUT_EN
        wd_n = wd_q + 1'b1;
`endif
        if (bready_q && m_axi.bvalid) begin
          bready_n = 1'b0;
          if (m_axi.bresp != 2'b00) begin
            // A failed write never leads to RUN; drain the rest unless TLAST is already in hand
            err_resp_n = 1'b1;
            state_n    = tlast_q ? S_IDLE : S_DRAIN;
            busy_n     = !tlast_q;
          end else begin
            case (state)
              S_STOP: begin state_n = S_PTR; awvalid_n = 1'b1; wvalid_n = 1'b1; end
              S_PTR:  state_n = S_FETCH;
              S_LO:   begin state_n = S_HI; awvalid_n = 1'b1; wvalid_n = 1'b1; end
              S_HI: begin
                count_n = count_q + 1'b1;
                if (tlast_q) begin
                  state_n   = S_RUN;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                end else begin
                  state_n = S_FETCH;
                end
              end
              default: begin state_n = S_IDLE; busy_n = 1'b0; done_n = 1'b1; end
            endcase
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          awvalid_n  = 1'b0;
          wvalid_n   = 1'b0;
          bready_n   = 1'b0;
          err_resp_n = 1'b1;
          state_n    = tlast_q ? S_IDLE : S_DRAIN;
          busy_n     = !tlast_q;
        end
`endif
      end
    endcase
`ifdef LOADER_TIMEOUT_EN
    if (state_n != state) wd_n = '0;
`endif
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state     <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_resp  <= 1'b0;
      err_ovf   <= 1'b0;
      count_q   <= '0;
      tlast_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state     <= state_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      busy      <= busy_n;
      done      <= done_n;
      err_resp  <= err_resp_n;
      err_ovf   <= err_ovf_n;
      count_q   <= count_n;
      tlast_q   <= tlast_n;
`ifdef LOADER_TIMEOUT_EN
      wd_q      <= wd_n;
`endif
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (fetch_fire) instr_q <= instr_TDATA;
  end

endmodule

// File: tb/tb_bpf_axilite_code_loader.sv
// Directed bench for bpf_axilite_code_loader: stream source, AXI-Lite slave model
// with configurable awready delay / error response / held B, per-scenario checks.
module tb_bpf_axilite_code_loader;
  localparam int          AW   = 12;
  localparam logic [11:0] BASE = 12'h100;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic        tvalid, tlast, tready;
  logic        busy, done, err_resp, err_ovf;

  bpf_axilite_code_loader_if #(.AXI_ADDR_WIDTH(AW)) axi ();

  bpf_axilite_code_loader #(
    .AXI_ADDR_WIDTH (AW),
    .CODE_ADDR_WIDTH(2),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .axi_aclk    (clk),
    .axi_areset  (rst),
    .instr_TDATA (tdata),
    .instr_TVALID(tvalid),
    .instr_TLAST (tlast),
    .instr_TREADY(tready),
    .m_axi       (axi),
    .busy        (busy),
    .done        (done),
    .err_resp    (err_resp),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  word_t       sq[$];
  logic [11:0] aw_log[$];
  logic [31:0] w_log[$];
  int          b_cnt, done_cnt;
  int          aw_delay = 0;
  int          err_idx  = -1;
  bit          b_hold   = 1'b0;
  int          n_cmp = 0, n_fail = 0;

  // Source and slave drive on the falling edge
  initial begin
    int aw_wait;
    aw_wait = 0;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aw_wait = 0;
      end else begin
        if (sq.size() > 0) begin
          tvalid = 1'b1; tdata = sq[0].d; tlast = sq[0].l;
        end else begin
          tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        end
        if (axi.awvalid && aw_wait >= aw_delay) axi.awready = 1'b1;
        else begin
          axi.awready = 1'b0;
          aw_wait = axi.awvalid ? aw_wait + 1 : 0;
        end
        axi.wready = axi.wvalid;
        if (axi.bready && !b_hold) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
        end else begin
          axi.bvalid = 1'b0;
          axi.bresp  = 2'b00;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (tvalid && tready && sq.size() > 0) void'(sq.pop_front());
        if (axi.awvalid && axi.awready) aw_log.push_back(axi.awaddr);
        if (axi.wvalid && axi.wready) w_log.push_back(axi.wdata);
        if (axi.bvalid && axi.bready) b_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); b_cnt = 0; done_cnt = 0;
  endtask

  // Word i: LO = {seed, 8'h10, i}, HI = {seed, 8'h20, i}; TLAST on the last one
  task automatic load(input int n, input logic [15:0] seed);
    for (int i = 0; i < n; i++)
      sq.push_back('{d: {seed, 8'h20, 8'(i), seed, 8'h10, 8'(i)}, l: (i == n - 1)});
  endtask

  task automatic wait_prog(input int max, output bit ok);
    bit seen;
    seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (busy) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (axi.awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %b want 0", axi.awvalid); end
    n_cmp++; if (axi.wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b want 0", axi.wvalid); end
    n_cmp++; if (axi.bready !== 1'b0) begin n_fail++; $display("FAIL reset_bready: got %b want 0", axi.bready); end
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", tready); end
    n_cmp++; if ({busy, done, err_resp, err_ovf} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: got %b want 0000", {busy, done, err_resp, err_ovf});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL idle_tready: got %b want 0", tready); end
  endtask

  task automatic test_basic();
    logic [11:0] exp_aw[9] = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h108, 12'h10C,
                               12'h108, 12'h10C, 12'h100};
    logic [31:0] exp_w[9]  = '{32'h0, 32'h0, 32'hA5A5_1000, 32'hA5A5_2000, 32'hA5A5_1001,
                               32'hA5A5_2001, 32'hA5A5_1002, 32'hA5A5_2002, 32'h1};
    bit ok;
    logic [11:0] ga;
    logic [31:0] gw;
    clear_logs();
    load(3, 16'hA5A5);
    wait_prog(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_complete: got %b want 1", ok); end
    n_cmp++; if (aw_log.size() !== 9) begin n_fail++; $display("FAIL basic_aw_count: got %0d want 9", aw_log.size()); end
    for (int i = 0; i < 9; i++) begin
      ga = (i < aw_log.size()) ? aw_log[i] : 'x;
      gw = (i < w_log.size()) ? w_log[i] : 'x;
      n_cmp++; if (ga !== exp_aw[i]) begin n_fail++; $display("FAIL basic_awaddr[%0d]: got %h want %h", i, ga, exp_aw[i]); end
      n_cmp++; if (gw !== exp_w[i]) begin n_fail++; $display("FAIL basic_wdata[%0d]: got %h want %h", i, gw, exp_w[i]); end
    end
    n_cmp++; if (b_cnt !== 9) begin n_fail++; $display("FAIL basic_b_count: got %0d want 9", b_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cycles: got %0d want 1", done_cnt); end
    n_cmp++; if ({err_resp, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL basic_err: got %b want 00", {err_resp, err_ovf}); end
    n_cmp++; if (sq.size() !== 0) begin n_fail++; $display("FAIL basic_consumed: got %0d left want 0", sq.size()); end
  endtask

  task automatic test_aw_delay();
    bit ok, hit;
    clear_logs();
    aw_delay = 3;
    load(1, 16'h3C3C);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      hit = axi.awvalid;
    end
    n_cmp++; if (hit !== 1'b1 || axi.wvalid !== 1'b1) begin
      n_fail++; $display("FAIL awd_entry: got aw=%b w=%b want 1 1", hit, axi.wvalid);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100 || axi.awaddr !== BASE) begin
        n_fail++; $display("FAIL awd_hold[%0d]: got aw/w/b=%b addr=%h want 100 %h", k,
                           {axi.awvalid, axi.wvalid, axi.bready}, axi.awaddr, BASE);
      end
    end
    @(posedge clk); #1;
    n_cmp++; if ({axi.awvalid, axi.bready} !== 2'b01) begin
      n_fail++; $display("FAIL awd_accept: got aw/b=%b want 01", {axi.awvalid, axi.bready});
    end
    @(posedge clk); #1;
    n_cmp++; if (b_cnt !== 1) begin n_fail++; $display("FAIL awd_single_b: got %0d want 1", b_cnt); end
    wait_prog(200, ok);
    aw_delay = 0;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL awd_complete: got %b want 1", ok); end
    n_cmp++; if (b_cnt !== 5) begin n_fail++; $display("FAIL awd_b_count: got %0d want 5", b_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL awd_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_bresp_err();
    bit ok;
    clear_logs();
    err_idx = 4;
    load(4, 16'h7E7E);
    wait_prog(300, ok);
    err_idx = -1;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL berr_complete: got %b want 1", ok); end
    n_cmp++; if (aw_log.size() !== 5) begin n_fail++; $display("FAIL berr_aw_count: got %0d want 5", aw_log.size()); end
    n_cmp++; if (aw_log.size() != 5 || aw_log[4] !== 12'h108) begin
      n_fail++; $display("FAIL berr_last_addr: got size %0d want last 108", aw_log.size());
    end
    n_cmp++; if (err_resp !== 1'b1) begin n_fail++; $display("FAIL berr_flag: got %b want 1", err_resp); end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL berr_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (sq.size() !== 0) begin n_fail++; $display("FAIL berr_drained: got %0d left want 0", sq.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL berr_busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_logs();
    load(6, 16'h0F0F);
    wait_prog(400, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_complete: got %b want 1", ok); end
    n_cmp++; if (aw_log.size() !== 10) begin n_fail++; $display("FAIL ovf_aw_count: got %0d want 10", aw_log.size()); end
    n_cmp++; if (w_log.size() != 10 || w_log[9] !== 32'h0F0F_2003) begin
      n_fail++; $display("FAIL ovf_last_data: got size %0d want last 0f0f2003", w_log.size());
    end
    n_cmp++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", err_ovf); end
    n_cmp++; if (err_resp !== 1'b0) begin n_fail++; $display("FAIL ovf_resp_cleared: got %b want 0", err_resp); end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL ovf_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (sq.size() !== 0) begin n_fail++; $display("FAIL ovf_drained: got %0d left want 0", sq.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    clear_logs();
    load(3, 16'h5A5A);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      hit = axi.awvalid && (axi.awaddr == BASE + 12'hC);
    end
    n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_hi: got %b want 1", hit); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid, busy, tready} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_async: got aw/w/busy/tready=%b want 0000",
                         {axi.awvalid, axi.wvalid, busy, tready});
    end
    sq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    load(2, 16'h9999);
    wait_prog(300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_reload: got %b want 1", ok); end
    n_cmp++; if (aw_log.size() !== 7) begin n_fail++; $display("FAIL rmid_aw_count: got %0d want 7", aw_log.size()); end
    n_cmp++; if (w_log.size() != 7 || w_log[5] !== 32'h9999_2001 || w_log[6] !== 32'h1) begin
      n_fail++; $display("FAIL rmid_data: got size %0d want tail 99992001,1", w_log.size());
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rmid_done: got %0d want 1", done_cnt); end
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    clear_logs();
    b_hold = 1'b1;
    load(2, 16'h4444);
    wait_prog(200, ok);
    b_hold = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_complete: got %b want 1", ok); end
    n_cmp++; if (err_resp !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", err_resp); end
    n_cmp++; if (aw_log.size() !== 1 || b_cnt !== 0) begin
      n_fail++; $display("FAIL tmo_writes: got aw=%0d b=%0d want 1 0", aw_log.size(), b_cnt);
    end
    n_cmp++; if (axi.bready !== 1'b0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL tmo_quiet: got bready=%b done=%0d want 0 0", axi.bready, done_cnt);
    end
    n_cmp++; if (sq.size() !== 0) begin n_fail++; $display("FAIL tmo_drained: got %0d left want 0", sq.size()); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_err();
    test_overflow();
    test_reset_mid();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
